perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Parametrised bank of N_CH event counters for the single-cycle/pipelined MIPS CPU, e.g. total cycles, branches taken, jumps and stalls.
- Adds halt-on-exit-syscall with resume, wrap or saturate mode, sticky overflow flags and synchronous soft clear.
- Adds a muxed readout port for the seven-segment/debug display path.
- Sits beside the datapath; its only inputs are decoded control strobes from the controller.

Parameters:
N_CH, 3, number of counter channels (1..16)
CNT_W, 32, counter width in bits (8..32)
SAT_MODE, 0, 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones
HALT_CODE, 10, syscall service code ($v0 value) that freezes counting
SEL_W, $clog2(N_CH) (minimum 1), width of the read select

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
soft_clr  in  1  synchronous clear of counters, flags and state
ev  in  N_CH  per-channel event strobe; counts when 1 on a clock edge
syscall  in  1  syscall instruction in the counted stage this cycle
sys_code  in  32  $v0 value accompanying syscall
resume  in  1  leave HALTED state
snap  in  1  capture snapshot (used only with feature)
sel  in  SEL_W  channel read select
rd_data  out  CNT_W  selected counter value
ovf  out  N_CH  sticky per-channel overflow flags
halted  out  1  1 while in HALTED state

Behaviour:
- Reset (clr_n=0, async): all counters 0, ovf 0, state RUN, halted 0, shadow registers 0.
- State machine, two states:
  - RUN: counters active.
  - HALTED: counters frozen.
- RUN -> HALTED:
  - Transition on the edge where syscall=1 and sys_code==HALT_CODE.
  - Events on that same edge ARE counted; the exit syscall itself is included.
  - A syscall with any other code has no effect and is counted normally.
- HALTED -> RUN:
  - Transition on the edge where resume=1.
  - Events on the resume edge are NOT counted; counting restarts on the next edge.
- In HALTED, further syscalls are ignored; ev is ignored.
- Counting: in RUN, each channel i with ev[i]=1 increments by 1 per edge. Channels are independent, and simultaneous events on all channels are all counted.
- Overflow:
  - Applies to an increment from 2^CNT_W-1.
  - SAT_MODE=0: counter becomes 0 and ovf[i] is set.
  - SAT_MODE=1: counter stays 2^CNT_W-1 and ovf[i] is set.
  - ovf[i] stays set until reset or soft_clr.
- soft_clr:
  - Effect on the next edge: all counters 0, ovf 0, state RUN.
  - Takes priority over ev, syscall, resume and snap in the same cycle.
- Readout:
  - rd_data = counter[sel], combinational, zero latency.
  - sel >= N_CH gives 0.
- halted: registered, equal to (state==HALTED).
- No X propagation: all outputs driven from reset onward.

Optional Feature:
PERF_CNT_SNAPSHOT_EN
- Defined:
  - A shadow register per channel captures all live counters on the edge where snap=1 and soft_clr=0, so all channels are captured coherently.
  - The captured value is the pre-increment value at that edge.
  - rd_data reads shadow[sel] instead of the live counter.
  - Shadow registers are cleared by reset and by soft_clr.
- Undefined: no shadow storage, snap is ignored, rd_data reads live counters.

Decomposition:
- Shared package perf_pkg holds:
  - the state encoding typedef (PC_RUN, PC_HALTED);
  - the default HALT_CODE constant (10);
  - the default channel indices CH_CYCLE=0, CH_BRANCH=1, CH_JMP=2.
- One natural sub-module: perf_counter_cell, a single CNT_W counter with enable, soft clear, wrap/saturate and sticky overflow. The bank instantiates N_CH of these via generate; the state machine, readout mux and shadow logic live in the top.

Test Plan:
- Reset then ev=3'b111 for 5 cycles, sel=0,1,2 -> rd_data=5 on each; ovf=0; halted=0.
- ev[0]=1 every cycle, syscall with sys_code=10 on cycle 7 -> ch0 stops at 7, halted=1.
  - A later syscall with sys_code=4 has no effect.
  - resume at cycle 12, then 3 more cycles -> ch0=10.
- CNT_W=8, SAT_MODE=0, 257 events on ch1 -> rd_data=1, ovf[1]=1.
  - Repeat with SAT_MODE=1 -> rd_data=255, ovf[1]=1.
- soft_clr asserted with ev=3'b111 and syscall/sys_code=10 in the same cycle -> all counters 0, ovf 0, halted 0 next cycle.
- Assert clr_n low mid-count, between clock edges -> outputs 0 immediately; sel=3 with N_CH=3 -> rd_data=0.
- With PERF_CNT_SNAPSHOT_EN: count ch0 to 20, pulse snap, count 5 more -> rd_data=20.
  - Without the macro, the same sequence gives rd_data=25.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: controller state
// encoding, default halt syscall code and default channel assignments.
package perf_pkg;

    typedef enum logic {
        PC_RUN    = 1'b0,
        PC_HALTED = 1'b1
    } pc_state_t;

    localparam logic [31:0] PERF_HALT_CODE = 32'd10;

    localparam int unsigned CH_CYCLE  = 0;
    localparam int unsigned CH_BRANCH = 1;
    localparam int unsigned CH_JMP    = 2;

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter: increment on enable, synchronous soft clear,
// wrap-to-zero or saturate at all-ones, and a sticky overflow flag.
module perf_counter_cell #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_soft_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_soft_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_inc) begin
            if (&r_cnt) begin
                // Overflowing increment: flag is sticky, value wraps or holds.
                r_ovf <= 1'b1;
                r_cnt <= (SAT_MODE != 0) ? r_cnt : '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of N_CH event counters with halt-on-exit-syscall, soft clear and a
// muxed readout. Define PERF_CNT_SNAPSHOT_EN to read coherent snapshots.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned N_CH      = 3,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned SAT_MODE  = 0,
    parameter logic [31:0] HALT_CODE = PERF_HALT_CODE,
    parameter int unsigned SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             soft_clr,
    input  logic [N_CH-1:0]  ev,
    input  logic             syscall,
    input  logic [31:0]      sys_code,
    input  logic             resume,
    input  logic             snap,
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [N_CH-1:0]  ovf,
    output logic             halted
);

    pc_state_t        r_state;
    logic             r_halted;
    logic             w_run;
    logic [CNT_W-1:0] w_cnt [N_CH];
    logic [CNT_W-1:0] w_rd;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= PC_RUN;
            r_halted <= 1'b0;
        end else if (soft_clr) begin
            r_state  <= PC_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                PC_RUN: begin
                    if (syscall && (sys_code == HALT_CODE)) begin
                        r_state  <= PC_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                PC_HALTED: begin
                    if (resume) begin
                        r_state  <= PC_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= PC_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Counting keys off the pre-edge state: the exit syscall edge still counts,
    // the resume edge does not.
    assign w_run = (r_state == PC_RUN);

    for (genvar g = 0; g < N_CH; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_cell (
            .clk        (clk),
            .clr_n      (clr_n),
            .i_soft_clr (soft_clr),
            .i_inc      (w_run & ev[g]),
            .o_cnt      (w_cnt[g]),
            .o_ovf      (ovf[g])
        );
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [CNT_W-1:0] r_shadow [N_CH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < N_CH; i++) r_shadow[i] <= '0;
        end else if (soft_clr) begin
            for (int unsigned i = 0; i < N_CH; i++) r_shadow[i] <= '0;
        end else if (snap) begin
            for (int unsigned i = 0; i < N_CH; i++) r_shadow[i] <= w_cnt[i];
        end
    end
`else
    logic w_unused_snap;
    assign w_unused_snap = snap;
`endif

    always_comb begin
        w_rd = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) begin
`ifdef PERF_CNT_SNAPSHOT_EN
                w_rd = r_shadow[i];
`else
                w_rd = w_cnt[i];
`endif
            end
        end
    end

    assign rd_data = w_rd;
    assign halted  = r_halted;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: three instances (32-bit wrap,
// 8-bit wrap, 8-bit saturate) share stimulus; a monitor checks queued expectations.
module tb_perf_counter_bank;

    logic        clk;
    logic        clr_n;
    logic        soft_clr;
    logic [2:0]  ev;
    logic        syscall;
    logic [31:0] sys_code;
    logic        resume;
    logic        snap;
    logic [1:0]  sel;

    logic [31:0] rd0;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic [2:0]  ovf0, ovf1, ovf2;
    logic        h0, h1, h2;

    typedef struct {
        int          dut;
        string       name;
        logic [31:0] rd;
        logic [2:0]  ovf;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    perf_counter_bank #(.N_CH(3), .CNT_W(32), .SAT_MODE(0)) u_dut0 (
        .clk(clk), .clr_n(clr_n), .soft_clr(soft_clr), .ev(ev),
        .syscall(syscall), .sys_code(sys_code), .resume(resume), .snap(snap),
        .sel(sel), .rd_data(rd0), .ovf(ovf0), .halted(h0)
    );

    perf_counter_bank #(.N_CH(3), .CNT_W(8), .SAT_MODE(0)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .soft_clr(soft_clr), .ev(ev),
        .syscall(syscall), .sys_code(sys_code), .resume(resume), .snap(snap),
        .sel(sel), .rd_data(rd1), .ovf(ovf1), .halted(h1)
    );

    perf_counter_bank #(.N_CH(3), .CNT_W(8), .SAT_MODE(1)) u_dut2 (
        .clk(clk), .clr_n(clr_n), .soft_clr(soft_clr), .ev(ev),
        .syscall(syscall), .sys_code(sys_code), .resume(resume), .snap(snap),
        .sel(sel), .rd_data(rd2), .ovf(ovf2), .halted(h2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the DUT outputs are presented at each falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a_rd;
        logic [2:0]  a_ovf;
        logic        a_h;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.dut)
                1:       begin a_rd = {24'd0, rd1}; a_ovf = ovf1; a_h = h1; end
                2:       begin a_rd = {24'd0, rd2}; a_ovf = ovf2; a_h = h2; end
                default: begin a_rd = rd0;          a_ovf = ovf0; a_h = h0; end
            endcase
            n_tests++;
            if (a_rd !== e.rd || a_ovf !== e.ovf || a_h !== e.halted) begin
                n_fail++;
                $display("FAIL %s: dut%0d got rd=%0d ovf=%b halted=%b, want rd=%0d ovf=%b halted=%b",
                         e.name, e.dut, a_rd, a_ovf, a_h, e.rd, e.ovf, e.halted);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ev = 3'b000; syscall = 1'b0; sys_code = 32'd0; resume = 1'b0;
        snap = 1'b0; soft_clr = 1'b0;
    endtask

    // Copies live counters into the shadows when snapshots are built in;
    // harmless otherwise since all other inputs are idle.
    task automatic view();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic chk(input int d, input string nm, input logic [1:0] s,
                       input logic [31:0] rd, input logic [2:0] ov, input logic h);
        exp_t e;
        sel = s;
        e.dut = d; e.name = nm; e.rd = rd; e.ovf = ov; e.halted = h;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr_n   = 1'b0;
        sel     = 2'd0;
        idle();

        // Reset state
        tick();
        chk(0, "reset_state", 2'd0, 32'd0, 3'b000, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;

        // All channels count together
        ev = 3'b111;
        repeat (5) tick();
        idle();
        view();
        chk(0, "all_ch_sel0", 2'd0, 32'd5, 3'b000, 1'b0);
        chk(0, "all_ch_sel1", 2'd1, 32'd5, 3'b000, 1'b0);
        chk(0, "all_ch_sel2", 2'd2, 32'd5, 3'b000, 1'b0);
        chk(1, "all_ch_w8",   2'd2, 32'd5, 3'b000, 1'b0);

        // Halt on exit syscall (counted), ignore events while halted
        soft_clr = 1'b1; tick(); soft_clr = 1'b0;
        ev = 3'b001;
        repeat (6) tick();
        syscall = 1'b1; sys_code = 32'd10;
        tick();
        syscall = 1'b0; sys_code = 32'd0;
        repeat (2) tick();
        syscall = 1'b1; sys_code = 32'd4;
        tick();
        idle();
        view();
        chk(0, "halt_freeze", 2'd0, 32'd7, 3'b000, 1'b1);

        // Resume edge not counted; non-exit syscall in RUN counted normally
        ev = 3'b001; resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        syscall = 1'b1; sys_code = 32'd4;
        tick();
        syscall = 1'b0; sys_code = 32'd0;
        tick();
        idle();
        view();
        chk(0, "resume_count", 2'd0, 32'd10, 3'b000, 1'b0);
        chk(0, "resume_ch1",   2'd1, 32'd0,  3'b000, 1'b0);

        // Overflow: 257 events on ch1
        soft_clr = 1'b1; tick(); soft_clr = 1'b0;
        ev = 3'b010;
        repeat (257) tick();
        idle();
        view();
        chk(1, "wrap_w8",    2'd1, 32'd1,   3'b010, 1'b0);
        chk(2, "sat_w8",     2'd1, 32'd255, 3'b010, 1'b0);
        chk(0, "no_ovf_w32", 2'd1, 32'd257, 3'b000, 1'b0);

        // soft_clr beats events, exit syscall, resume and snap
        syscall = 1'b1; sys_code = 32'd10;
        tick();
        idle();
        chk(2, "halt_before_clr", 2'd1, 32'd255, 3'b010, 1'b1);
        soft_clr = 1'b1; ev = 3'b111; syscall = 1'b1; sys_code = 32'd10;
        resume = 1'b1; snap = 1'b1;
        tick();
        idle();
        view();
        chk(0, "softclr_ch0", 2'd0, 32'd0, 3'b000, 1'b0);
        chk(0, "softclr_ch2", 2'd2, 32'd0, 3'b000, 1'b0);
        chk(2, "softclr_ovf", 2'd1, 32'd0, 3'b000, 1'b0);

        // Asynchronous reset between edges, while halted with counts held
        ev = 3'b111;
        repeat (3) tick();
        syscall = 1'b1; sys_code = 32'd10;
        tick();
        idle();
        #2;
        clr_n = 1'b0;
        chk(0, "async_reset", 2'd0, 32'd0, 3'b000, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        ev = 3'b111;
        repeat (2) tick();
        idle();
        view();
        chk(0, "sel_out_of_range", 2'd3, 32'd0, 3'b000, 1'b0);
        chk(0, "after_reset_cnt",  2'd2, 32'd2, 3'b000, 1'b0);

        // Snapshot: count to 20, snap, 5 more events
        soft_clr = 1'b1; tick(); soft_clr = 1'b0;
        ev = 3'b001;
        repeat (20) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        repeat (4) tick();
        idle();
`ifdef PERF_CNT_SNAPSHOT_EN
        chk(0, "snapshot", 2'd0, 32'd20, 3'b000, 1'b0);
`else
        chk(0, "snapshot", 2'd0, 32'd25, 3'b000, 1'b0);
`endif

        repeat (4) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
